// File: rtl/spike_reset_mux.sv
// Spike detect and reset-select mux: fires when v >= THRESH (signed, inclusive),
// forwards b on a spike and a otherwise, with a registered copy for the state stage.
module spike_reset_mux #(
  parameter int                       WIDTH  = 21,
  parameter int                       FRAC   = 9,
  parameter logic signed [WIDTH-1:0]  THRESH = 21'sd15360
) (
  input  logic signed [WIDTH-1:0] v,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  input  logic                    clk,
  input  logic                    rst,
  output logic                    spike,
  output logic signed [WIDTH-1:0] c_q,
  output logic                    spike_q
);

  // The fixed-point format needs at least a sign bit above the fraction.
  if (FRAC >= WIDTH) begin : g_bad_format
    $error("spike_reset_mux: FRAC must be smaller than WIDTH");
  end

  always_comb begin
    spike = (v >= THRESH);
    c     = spike ? b : a;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      c_q     <= c;
      spike_q <= spike;
    end
  end

endmodule

// File: tb/tb_spike_reset_mux.sv
// Randomized self-checking bench for spike_reset_mux against an integer-valued
// reference of the firing rule (threshold +30.0 in Q12.9).
module tb_spike_reset_mux;

  localparam int W = 21;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [W-1:0] v  = '0;
  logic signed [W-1:0] a  = '0;
  logic signed [W-1:0] b  = '0;
  logic signed [W-1:0] c;
  logic                spike;
  logic signed [W-1:0] c_q;
  logic                spike_q;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state for the registered outputs.
  logic [W-1:0] exp_cq = '0;
  logic         exp_sq = 1'b0;

  spike_reset_mux #(.WIDTH(21), .FRAC(9), .THRESH(21'sd15360)) dut (
    .v(v), .a(a), .b(b), .c(c), .clk(clk), .rst(rst),
    .spike(spike), .c_q(c_q), .spike_q(spike_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Potential in units of 1/512 compared against 30.0 volts-equivalent.
  function automatic bit ref_fire(input logic signed [W-1:0] pot);
    int value;
    value = pot;
    return value >= 30 * 512;
  endfunction

  // Drive inputs, check combinational outputs, then check the registered copy after the edge.
  task automatic apply(input string tag, input logic [W-1:0] nv, input logic [W-1:0] na,
                       input logic [W-1:0] nb, input logic nr);
    bit f;
    v = nv; a = na; b = nb; rst = nr;
    #1;
    f = ref_fire(nv);
    check({tag, ".spike"}, {20'd0, spike}, {20'd0, f});
    check({tag, ".c"}, c, f ? nb : na);
    @(posedge clk);
    exp_cq = nr ? '0 : (f ? nb : na);
    exp_sq = nr ? 1'b0 : f;
    #1;
    check({tag, ".c_q"}, c_q, exp_cq);
    check({tag, ".spike_q"}, {20'd0, spike_q}, {20'd0, exp_sq});
  endtask

  localparam logic [W-1:0] A15  = 21'h001E00;
  localparam logic [W-1:0] BM65 = 21'h1F7E00;

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.c_q", c_q, '0);
    check("reset.spike_q", {20'd0, spike_q}, '0);

    apply("v20",    21'h002800, A15, BM65, 1'b0);
    apply("v50",    21'h006400, A15, BM65, 1'b0);
    apply("vm80",   21'h1F6000, A15, BM65, 1'b0);
    apply("thr_eq", 21'h003C00, A15, BM65, 1'b0);
    apply("thr_m1", 21'h003BFF, A15, BM65, 1'b0);
    apply("vmax",   21'h0FFFFF, A15, BM65, 1'b0);
    apply("vmin",   21'h100000, A15, BM65, 1'b0);

    // Reset held with a firing input: comb path unaffected, register cleared.
    apply("rst_hold", 21'h006400, A15, BM65, 1'b1);
    apply("rst_drop", 21'h006400, A15, BM65, 1'b0);

    // Raising rst mid-cycle must not touch c_q before the next edge.
    rst = 1'b1;
    #2;
    check("rst_mid.c_q", c_q, exp_cq);
    check("rst_mid.spike_q", {20'd0, spike_q}, {20'd0, exp_sq});
    @(posedge clk);
    #1;
    check("rst_mid_edge.c_q", c_q, '0);
    check("rst_mid_edge.spike_q", {20'd0, spike_q}, '0);

    // Randomized traffic, half of it clustered around the threshold.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] rv;
      if ($urandom_range(1, 0) == 1)
        rv = W'(15360 + int'($urandom_range(16, 0)) - 8);
      else
        rv = W'($urandom);
      apply("rand", rv, W'($urandom), W'($urandom), $urandom_range(9, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_reset_mux.md
# spike_reset_mux

Spike-detect and reset-select multiplexer for the digital neuron datapath. It compares the membrane potential `v` against a fixed firing threshold. It forwards either the freshly computed next-state value `a` or the post-spike reset value `b`. The selected value is available both combinationally and as a registered copy, together with a spike flag, for the neuron state register stage.

## Interface
- `WIDTH`, default 21: word width of all data ports. Values are signed two's complement.
- `FRAC`, default 9: number of fractional bits. The format is Q12.9 (12 integer bits including sign, 9 fractional bits).
- `THRESH`, default 21'sd15360: firing threshold, +30.0 in Q12.9.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `v`  in  WIDTH signed  membrane potential.
- `a`  in  WIDTH signed  next-state value used when there is no spike.
- `b`  in  WIDTH signed  reset value used on a spike (e.g. −65.0).
- `c`  out  WIDTH signed  selected value, combinational.
- `spike`  out  1  combinational flag; 1 when `v >= THRESH`.
- `c_q`  out  WIDTH signed  registered copy of `c`.
- `spike_q`  out  1  registered copy of `spike`.

Positional port order is fixed as `v, a, b, c, clk, rst, spike, c_q, spike_q`. This lets existing 4-port positional instantiations keep working.

## Operation
- `spike = ($signed(v) >= $signed(THRESH))`. The comparison is full-width signed; there is no truncation or rounding.
- `c = spike ? b : a`. Values pass bit-exact, with no saturation or rescaling.
- Negative `v` (any value with the MSB set) never fires. This includes the most negative value, 21'h100000.
- `v` exactly equal to `THRESH` fires (the comparison is inclusive).
- `c` and `spike` are purely combinational. They settle within the same delta/cycle as any input change and do not depend on `clk` or `rst`.
- On each rising edge of `clk`:
  - If `rst` = 1: `c_q` <= 0 and `spike_q` <= 0.
  - Otherwise: `c_q` <= `c` and `spike_q` <= `spike`.
- The block has no other state and no state machine.

## Timing
- `c` and `spike` have zero-cycle latency (combinational).
- `c_q` and `spike_q` have a latency of 1 cycle after the inputs are sampled at the rising edge.
- Reset values are `c_q` = 0 and `spike_q` = 0.
- Reset is synchronous. Asserting `rst` has no effect on `c_q` and `spike_q` until the next rising edge.
- Reset has no effect on the combinational outputs `c` and `spike`.
- Reset asserted mid-stream overrides whatever is sampled that edge. The first valid registered output appears 1 cycle after `rst` deasserts.
- Input changes between edges are visible on `c` immediately. They reach `c_q` only at the next edge.

## Test plan
- v=+20.0 (21'h002800), a=+15.0 (21'h001E00), b=−65.0 (21'h1F7E00): expect c=21'h001E00 and spike=0. After one edge, c_q=21'h001E00.
- v=+50.0 (21'h006400), same a/b: expect c=21'h1F7E00 and spike=1. After one edge, spike_q=1 and c_q=21'h1F7E00.
- v=−80.0 (21'h1F6000), same a/b: expect c=a=21'h001E00 and spike=0. This checks that negative v is handled as signed.
- Threshold boundary:
  - v=21'h003C00 (exactly 30.0): expect c=b, spike=1.
  - v=21'h003BFF: expect c=a, spike=0.
- Extremes:
  - v=21'h0FFFFF: expect c=b.
  - v=21'h100000: expect c=a.
- Reset behaviour:
  - Hold rst=1 with v=+50.0: after the edge, c_q=0 and spike_q=0, while c=b combinationally.
  - Drop rst: after the next edge, c_q=b and spike_q=1.
  - Raising rst between edges leaves c_q unchanged until the following edge.
